ram_read_checker: RTL and testbench

- Read-side counterpart of the dual-port RAM writer: sweeps port B of the 2-port RAM and verifies every word against the pattern the writer stores.
- Issues addresses on port B, aligns returned q_b with a latency-matched pipeline, counts mismatches, and reports pass/fail.
- Sits beside the dual-port RAM on the read-clock domain. Drives address_b/wren_b in place of the controller's read half.

---
 rtl/ram_read_checker_pkg.sv | 20 ++
 rtl/ram_read_checker_if.sv | 23 ++
 rtl/ram_read_checker_rd_align_pipe.sv | 35 +++
 rtl/ram_read_checker.sv | 121 ++++++++++++
 tb/tb_ram_read_checker.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_read_checker_pkg.sv
// Shared definitions for the port-B read checker: FSM states and the stored
// data pattern that the RAM writer produces and the checker expects back.
package ram_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  // Wide enough to count the drain phase for any read latency up to 4.
  localparam int DRAIN_CNT_W = 3;

  // Pattern word for an address; callers truncate to their RAM word width.
  function automatic logic [31:0] exp_word(input logic [31:0] addr, input logic [31:0] seed);
    return addr + seed;
  endfunction

endpackage

// File: rtl/ram_read_checker_if.sv
// Port-B connection between the read checker and the dual-port RAM.
interface ram_read_checker_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);

  logic [ADDR_W-1:0] address_b;
  logic              wren_b;
  logic [DATA_W-1:0] q_b;

  modport master (
    output address_b,
    output wren_b,
    input  q_b
  );

  modport slave (
    input  address_b,
    input  wren_b,
    output q_b
  );

endinterface

// File: rtl/ram_read_checker_rd_align_pipe.sv
// Delays each issued read address by the RAM read latency so it lines up with
// the q_b word that address produces.
module rd_align_pipe #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr
);

  logic [RD_LAT-1:0] valid_q;
  logic [ADDR_W-1:0] addr_q [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      addr_q  <= '{default: '0};
    end else begin
      valid_q[0] <= in_valid;
      addr_q[0]  <= in_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[RD_LAT-1];
  assign out_addr  = addr_q[RD_LAT-1];

endmodule

// File: rtl/ram_read_checker.sv
// Sweeps RAM port B over DEPTH words, compares each returned word with the
// writer's pattern and reports mismatch count, first failing address and pass.
module ram_read_checker
  import ram_chk_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2,
  parameter int SEED   = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  ram_read_checker_if.master  ram_b,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ADDR_W:0]     err_cnt,
  output logic [ADDR_W-1:0]   first_err_addr
);

  localparam logic [ADDR_W-1:0]      LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [DRAIN_CNT_W-1:0] LAST_DRAIN = DRAIN_CNT_W'(RD_LAT - 1);
  localparam logic [ADDR_W:0]        ERR_MAX    = '1;

  state_t                  state, state_nxt;
  logic [ADDR_W-1:0]       addr_q;
  logic [DRAIN_CNT_W-1:0]  drain_cnt;
  logic                    accept;
  logic                    pipe_valid;
  logic [ADDR_W-1:0]       pipe_addr;
  logic [DATA_W-1:0]       exp_data;
  logic                    mismatch;
  logic [ADDR_W:0]         err_nxt;

  rd_align_pipe #(
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_align (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (state == READ),
    .in_addr   (addr_q),
    .out_valid (pipe_valid),
    .out_addr  (pipe_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A start arriving while a sweep is in progress is deliberately not seen.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = READ;
          accept    = 1'b1;
        end
      end
      READ:    if (addr_q == LAST_ADDR) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == LAST_DRAIN) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  assign exp_data = DATA_W'(exp_word(32'(pipe_addr), 32'(SEED)));
  assign mismatch = pipe_valid && (ram_b.q_b != exp_data);

  always_comb begin
    err_nxt = err_cnt;
    if (accept) begin
      err_nxt = '0;
    end else if (mismatch && (err_cnt != ERR_MAX)) begin
      err_nxt = err_cnt + 1'b1;
    end
  end

  // The last compare retires on the edge that enters DONE, so pass uses err_nxt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q         <= '0;
      drain_cnt      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else begin
      err_cnt <= err_nxt;
      if (accept) begin
        addr_q         <= '0;
        drain_cnt      <= '0;
        busy           <= 1'b1;
        done           <= 1'b0;
        pass           <= 1'b0;
        first_err_addr <= '0;
      end else begin
        if (mismatch && (err_cnt == '0)) first_err_addr <= pipe_addr;
        if ((state == READ) && (addr_q != LAST_ADDR)) addr_q <= addr_q + 1'b1;
        if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
        if ((state == DRAIN) && (state_nxt == DONE)) begin
          busy <= 1'b0;
          done <= 1'b1;
          pass <= (err_nxt == '0);
        end
      end
    end
  end

  assign ram_b.address_b = addr_q;
  assign ram_b.wren_b    = 1'b0;

endmodule

// File: tb/tb_ram_read_checker.sv
// Self-checking bench: two checkers (SEED 0 and 0x10) against behavioural
// 2-cycle-latency RAMs, with a cycle-level model of the expected outputs.
module tb_ram_read_checker;
  import ram_chk_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 2;
  localparam int SEED0  = 0;
  localparam int SEED1  = 16;
  localparam int SWEEP_CYCLES = DEPTH + RD_LAT + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  bit   chk_en = 1'b0;
  int   n_checks = 0;
  int   n_fails = 0;

  always #5 clk = ~clk;

  ram_read_checker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus0 ();
  ram_read_checker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();

  logic              busy0, done0, pass0, busy1, done1, pass1;
  logic [ADDR_W:0]   err_cnt0, err_cnt1;
  logic [ADDR_W-1:0] first0, first1;

  ram_read_checker #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .SEED(SEED0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .ram_b(bus0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err_cnt0), .first_err_addr(first0)
  );

  ram_read_checker #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .SEED(SEED1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .ram_b(bus1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err_cnt1), .first_err_addr(first1)
  );

  // Dual-port RAM read side: registered address, then registered output.
  logic [DATA_W-1:0] mem0 [DEPTH];
  logic [DATA_W-1:0] mem1 [DEPTH];
  logic [ADDR_W-1:0] ra0, ra1;

  always @(posedge clk) begin
    ra0      <= bus0.address_b;
    bus0.q_b <= mem0[ra0];
    ra1      <= bus1.address_b;
    bus1.q_b <= mem1[ra1];
  end

  // Expected behaviour of dut0: cycle n after the accepted start retires the
  // compare of address n-RD_LAT-1; done arrives at n == DEPTH+RD_LAT.
  bit m_busy, m_done, m_pass;
  int m_err, m_first, m_addr, m_n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_pass = 0;
      m_err = 0; m_first = 0; m_addr = 0; m_n = 0;
    end else if (start0 && !m_busy) begin
      m_busy = 1; m_done = 0; m_pass = 0;
      m_err = 0; m_first = 0; m_addr = 0; m_n = 0;
    end else if (m_busy) begin
      int a;
      m_n++;
      a = m_n - RD_LAT - 1;
      if (a >= 0 && a < DEPTH && mem0[a] != DATA_W'(a + SEED0)) begin
        if (m_err == 0) m_first = a;
        if (m_err != (2 ** (ADDR_W + 1)) - 1) m_err++;
      end
      if (m_n < DEPTH) m_addr = m_n;
      if (m_n == DEPTH + RD_LAT) begin
        m_busy = 0;
        m_done = 1;
        m_pass = (m_err == 0);
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, actual, actual, expected, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("busy", int'(busy0), int'(m_busy));
      checkOutput("done", int'(done0), int'(m_done));
      checkOutput("pass", int'(pass0), int'(m_pass));
      checkOutput("err_cnt", int'(err_cnt0), m_err);
      checkOutput("first_err_addr", int'(first0), m_first);
      checkOutput("address_b", int'(bus0.address_b), m_addr);
      checkOutput("wren_b", int'(bus0.wren_b), 0);
    end
  end

  // Pulses start on the selected checker and counts edges (the sampling edge
  // is cycle 1) until done is seen; optionally re-pulses start mid-sweep.
  task automatic applyStimulus(input bit sel, input int busy_start_at, output int cycles);
    logic d;
    @(negedge clk);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    cycles = 1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    d = sel ? done1 : done0;
    while (!d && cycles < 3000) begin
      if (cycles == busy_start_at) begin
        if (sel) start1 = 1'b1; else start0 = 1'b1;
      end else begin
        start0 = 1'b0;
        start1 = 1'b0;
      end
      @(posedge clk);
      cycles++;
      @(negedge clk);
      d = sel ? done1 : done0;
    end
    start0 = 1'b0;
    start1 = 1'b0;
    if (!d) checkOutput("sweep_timeout", 0, 1);
  endtask

  initial begin
    int cyc;
    int guard;
    logic [31:0] pat;
    for (int a = 0; a < DEPTH; a++) begin
      mem0[a] = DATA_W'(a + SEED0);
      mem1[a] = DATA_W'(a + SEED1);
    end
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    checkOutput("rst_busy", int'(busy0), 0);
    checkOutput("rst_done", int'(done0), 0);
    checkOutput("rst_pass", int'(pass0), 0);
    checkOutput("rst_err_cnt", int'(err_cnt0), 0);
    checkOutput("rst_address_b", int'(bus0.address_b), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] clean sweep");
    applyStimulus(1'b0, -1, cyc);
    checkOutput("clean_latency", cyc, 1027);
    checkOutput("clean_pass", int'(pass0), 1);
    checkOutput("clean_err_cnt", int'(err_cnt0), 0);
    checkOutput("clean_first", int'(first0), 0);

    $display("[TB] single fault at 0x155");
    mem0[10'h155] = 8'h00;
    applyStimulus(1'b0, -1, cyc);
    checkOutput("single_pass", int'(pass0), 0);
    checkOutput("single_err_cnt", int'(err_cnt0), 1);
    checkOutput("single_first", int'(first0), 'h155);
    mem0[10'h155] = 8'h55;

    $display("[TB] faults at 0x003, 0x200, 0x3FF");
    mem0[10'h003] = 8'hAA;
    mem0[10'h200] = 8'h01;
    mem0[10'h3FF] = 8'h00;
    applyStimulus(1'b0, -1, cyc);
    checkOutput("multi_latency", cyc, SWEEP_CYCLES);
    checkOutput("multi_pass", int'(pass0), 0);
    checkOutput("multi_err_cnt", int'(err_cnt0), 3);
    checkOutput("multi_first", int'(first0), 'h003);
    mem0[10'h003] = 8'h03;
    mem0[10'h200] = 8'h00;
    mem0[10'h3FF] = 8'hFF;

    $display("[TB] seed 0x10 with data wrap");
    pat = exp_word(32'h0F0, 32'h10);
    checkOutput("exp_word_wrap", int'(pat[7:0]), 0);
    applyStimulus(1'b1, -1, cyc);
    checkOutput("seed_latency", cyc, 1027);
    checkOutput("seed_pass", int'(pass1), 1);
    checkOutput("seed_err_cnt", int'(err_cnt1), 0);
    checkOutput("seed_first", int'(first1), 0);

    $display("[TB] start while busy, then restart from DONE");
    mem0[10'h155] = 8'h00;
    applyStimulus(1'b0, 500, cyc);
    checkOutput("busy_start_latency", cyc, 1027);
    checkOutput("busy_start_err_cnt", int'(err_cnt0), 1);
    checkOutput("busy_start_first", int'(first0), 'h155);
    mem0[10'h155] = 8'h55;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    checkOutput("restart_done_low", int'(done0), 0);
    checkOutput("restart_err_clr", int'(err_cnt0), 0);
    checkOutput("restart_busy", int'(busy0), 1);
    cyc = 1;
    while (!done0 && cyc < 3000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    checkOutput("restart_latency", cyc, 1027);
    checkOutput("restart_pass", int'(pass0), 1);

    $display("[TB] reset mid-sweep at address 0x100");
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    guard = 0;
    while (bus0.address_b != 10'h100 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("reach_addr_100", int'(bus0.address_b), 'h100);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", int'(busy0), 0);
    checkOutput("midrst_done", int'(done0), 0);
    checkOutput("midrst_err_cnt", int'(err_cnt0), 0);
    checkOutput("midrst_address_b", int'(bus0.address_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, -1, cyc);
    checkOutput("post_rst_latency", cyc, 1027);
    checkOutput("post_rst_pass", int'(pass0), 1);
    checkOutput("post_rst_err_cnt", int'(err_cnt0), 0);

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
